kanagawa_skid_fifo: RTL and testbench

- Parametrised successor of the single-overflow skid buffer: a registered-ready, registered-output elastic buffer with DEPTH entries and a configurable upstream ready latency.
- Cuts both the forward path (data/valid) and the backward path (ready) between pipeline stages. Supports upstream producers that react to ready READY_LATENCY cycles late.
- Detects upstream protocol violations.
- With DEPTH=2 and READY_LATENCY=0, cycle behaviour equals the existing skid buffer.

---
 rtl/kanagawa_skid_fifo.sv | 154 +++++++++++++++
 tb/tb_kanagawa_skid_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_skid_fifo.sv
// Elastic buffer with registered ready, registered head and DEPTH entries of storage.
// Tolerates upstream producers that see ready READY_LATENCY cycles late and flags beats sent without a grant.
module kanagawa_skid_fifo #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 2,
    parameter int READY_LATENCY = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           input_data_in,
    input  logic                       input_valid_in,
    output logic                       input_ready_out,
    output logic [WIDTH-1:0]           output_data_out,
    output logic                       output_valid_out,
    input  logic                       output_ready_in,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_out,
    output logic                       protocol_error_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int BD = DEPTH - 1;
    localparam int PW = (BD > 1) ? $clog2(BD) : 1;
    localparam int SW = CW + 4;

    generate
        if (WIDTH < 1 || READY_LATENCY < 0 || READY_LATENCY > 8 || DEPTH < READY_LATENCY + 2) begin : g_bad_params
            $error("kanagawa_skid_fifo: need WIDTH>=1, READY_LATENCY in 0..8 and DEPTH>=READY_LATENCY+2");
        end
    endgenerate

    // Output-facing and internal copies are kept as separate flops so the ports carry no internal fanout.
    (* preserve *) logic r_ready;
    (* preserve *) logic r_ready_int;
    (* preserve *) logic r_valid;
    (* preserve *) logic r_valid_int;

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_buf [BD];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic             r_error;

    logic             w_grant;
    logic             w_violation;
    logic [SW-1:0]    w_pending;
    logic             w_push;
    logic             w_pop;
    logic             w_buf_empty;
    logic             w_to_head;
    logic [CW-1:0]    w_count_next;
    logic             w_ready_next;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(BD - 1)) ? '0 : p + PW'(1);
    endfunction

    // The grant history only exists when the producer sees ready late; pending counts grants still in flight.
    generate
        if (READY_LATENCY == 0) begin : g_no_latency
            assign w_grant     = r_ready_int;
            assign w_pending   = '0;
            assign w_violation = 1'b0;
        end else begin : g_latency
            logic [READY_LATENCY-1:0] r_hist;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hist <= '0;
                end else begin
                    r_hist <= (r_hist << 1) | READY_LATENCY'(r_ready_int);
                end
            end

            assign w_grant     = r_hist[READY_LATENCY-1];
            assign w_violation = input_valid_in && !w_grant;

            always_comb begin
                w_pending = SW'(r_ready_int);
                for (int i = 0; i < READY_LATENCY - 1; i++) begin
                    w_pending = w_pending + SW'(r_hist[i]);
                end
            end
        end
    endgenerate

    assign w_push       = input_valid_in && w_grant;
    assign w_pop        = r_valid_int && output_ready_in;
    assign w_buf_empty  = (r_count <= CW'(1));
    assign w_to_head    = !r_valid_int || (w_buf_empty && w_pop);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_ready_next = (SW'(w_count_next) + w_pending) < SW'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_ready     <= 1'b1;
            r_ready_int <= 1'b1;
            r_valid     <= 1'b0;
            r_valid_int <= 1'b0;
            r_error     <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            r_count     <= w_count_next;
            r_ready     <= w_ready_next;
            r_ready_int <= w_ready_next;
            r_valid     <= (w_count_next != '0);
            r_valid_int <= (w_count_next != '0);
            r_error     <= r_error | w_violation;
            if (w_push && !w_to_head) begin
                r_wr_ptr <= ptrInc(r_wr_ptr);
            end
            if (w_pop && !w_buf_empty) begin
                r_rd_ptr <= ptrInc(r_rd_ptr);
            end
        end
    end

    // Payload storage is not reset; validity is carried entirely by r_count and r_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push && w_to_head) begin
                r_head <= input_data_in;
            end else if (w_pop && !w_buf_empty) begin
                r_head <= r_buf[r_rd_ptr];
            end
            if (w_push && !w_to_head) begin
                r_buf[r_wr_ptr] <= input_data_in;
            end
        end
    end

    assign input_ready_out    = r_ready;
    assign output_valid_out   = r_valid;
    assign output_data_out    = r_head;
    assign occupancy_out      = r_count;
    assign protocol_error_out = r_error;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_ready == r_ready_int);
            assert (r_valid == r_valid_int);
            assert (r_count <= CW'(DEPTH));
            assert (!(w_push && r_count == CW'(DEPTH)));
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (r_valid_int && !output_ready_in) |=> $stable(r_head));
`endif

endmodule

// File: tb/tb_kanagawa_skid_fifo.sv
// Directed bench for kanagawa_skid_fifo: three instances cover L=0 skid behaviour,
// L=2 violation/throughput/reset and L=3 latency-tolerant filling.
module tb_kanagawa_skid_fifo;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: DEPTH=2, READY_LATENCY=0
    logic [W-1:0] aDin = '0;
    logic [W-1:0] aDout;
    logic         aVin = 1'b0;
    logic         aRin = 1'b0;
    logic         aRdy, aVout, aErr;
    logic [1:0]   aOcc;

    // Instance B: DEPTH=4, READY_LATENCY=2
    logic [W-1:0] bDin = '0;
    logic [W-1:0] bDout;
    logic         bVin = 1'b0;
    logic         bRin = 1'b0;
    logic         bRdy, bVout, bErr;
    logic [2:0]   bOcc;

    // Instance C: DEPTH=6, READY_LATENCY=3
    logic [W-1:0] cDin = '0;
    logic [W-1:0] cDout;
    logic         cVin = 1'b0;
    logic         cRin = 1'b0;
    logic         cRdy, cVout, cErr;
    logic [2:0]   cOcc;

    kanagawa_skid_fifo #(.WIDTH(W), .DEPTH(2), .READY_LATENCY(0)) uA (
        .clk(clk), .rst(rst),
        .input_data_in(aDin), .input_valid_in(aVin), .input_ready_out(aRdy),
        .output_data_out(aDout), .output_valid_out(aVout), .output_ready_in(aRin),
        .occupancy_out(aOcc), .protocol_error_out(aErr)
    );

    kanagawa_skid_fifo #(.WIDTH(W), .DEPTH(4), .READY_LATENCY(2)) uB (
        .clk(clk), .rst(rst),
        .input_data_in(bDin), .input_valid_in(bVin), .input_ready_out(bRdy),
        .output_data_out(bDout), .output_valid_out(bVout), .output_ready_in(bRin),
        .occupancy_out(bOcc), .protocol_error_out(bErr)
    );

    kanagawa_skid_fifo #(.WIDTH(W), .DEPTH(6), .READY_LATENCY(3)) uC (
        .clk(clk), .rst(rst),
        .input_data_in(cDin), .input_valid_in(cVin), .input_ready_out(cRdy),
        .output_data_out(cDout), .output_valid_out(cVout), .output_ready_in(cRin),
        .occupancy_out(cOcc), .protocol_error_out(cErr)
    );

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int peak, guard;
    int bSent, bExp, cSent, cExp;
    int firstPush, firstOut, lastOut;

    // Upstream view of ready: bGrant/cGrant is the ready value seen READY_LATENCY cycles ago.
    logic [1:0] bHist  = '0;
    logic [2:0] cHist  = '0;
    logic       bGrant = 1'b0;
    logic       cGrant = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advances to the next falling edge and updates the modelled grant history.
    task automatic nextCycle();
        @(negedge clk);
        cycle++;
        if (rst) begin
            bGrant = 1'b0;
            cGrant = 1'b0;
            bHist  = {1'b0, bRdy};
            cHist  = {2'b00, cRdy};
        end else begin
            bGrant = bHist[1];
            cGrant = cHist[2];
            bHist  = {bHist[0], bRdy};
            cHist  = {cHist[1:0], cRdy};
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r);
        aVin = v;
        aDin = d;
        aRin = r;
    endtask

    task automatic doReset();
        rst  = 1'b1;
        aVin = 1'b0; bVin = 1'b0; cVin = 1'b0;
        aRin = 1'b0; bRin = 1'b0; cRin = 1'b0;
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        doReset();

        checkOutput("A reset ready", aRdy, 1);
        checkOutput("A reset valid", aVout, 0);
        checkOutput("A reset occ", aOcc, 0);
        checkOutput("A reset err", aErr, 0);
        checkOutput("B reset ready", bRdy, 1);
        checkOutput("B reset occ", bOcc, 0);
        checkOutput("B reset err", bErr, 0);
        checkOutput("C reset ready", cRdy, 1);
        checkOutput("C reset valid", cVout, 0);
        checkOutput("C reset occ", cOcc, 0);

        // Bypass: single beat visible one cycle after push, gone the cycle after.
        applyStimulus(1'b1, 16'h00A5, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("A bypass valid", aVout, 1);
        checkOutput("A bypass data", aDout, 32'h00A5);
        checkOutput("A bypass occ", aOcc, 1);
        checkOutput("A bypass ready", aRdy, 1);
        nextCycle();
        checkOutput("A bypass drained occ", aOcc, 0);
        checkOutput("A bypass drained valid", aVout, 0);
        checkOutput("A bypass drained ready", aRdy, 1);

        // Stall: 1 held, 2 buffered, 3 refused until downstream releases.
        applyStimulus(1'b1, 16'd1, 1'b0);
        nextCycle();
        checkOutput("A stall ready after 1", aRdy, 1);
        checkOutput("A stall occ after 1", aOcc, 1);
        applyStimulus(1'b1, 16'd2, 1'b0);
        nextCycle();
        checkOutput("A stall ready after 2", aRdy, 0);
        checkOutput("A stall occ after 2", aOcc, 2);
        checkOutput("A stall head 1", aDout, 1);
        applyStimulus(1'b1, 16'd3, 1'b0);
        nextCycle();
        checkOutput("A stall 3 refused occ", aOcc, 2);
        checkOutput("A stall 3 refused head", aDout, 1);
        checkOutput("A stall still full ready", aRdy, 0);
        applyStimulus(1'b1, 16'd3, 1'b1);
        nextCycle();
        checkOutput("A release head 2", aDout, 2);
        checkOutput("A release occ", aOcc, 1);
        checkOutput("A release ready", aRdy, 1);
        applyStimulus(1'b1, 16'd3, 1'b1);
        nextCycle();
        checkOutput("A release head 3", aDout, 3);
        checkOutput("A release occ steady", aOcc, 1);
        checkOutput("A release valid", aVout, 1);
        applyStimulus(1'b0, 16'd0, 1'b1);
        nextCycle();
        checkOutput("A final empty occ", aOcc, 0);
        checkOutput("A final empty valid", aVout, 0);
        applyStimulus(1'b0, 16'd0, 1'b0);

        // Latency L=3: send on every grant while stalled, peak must reach 6 without a drop.
        doReset();
        peak  = 0;
        cSent = 0;
        cExp  = 0;
        for (int i = 0; i < 10; i++) begin
            if (int'(cOcc) > peak) peak = int'(cOcc);
            cVin = cGrant;
            if (cGrant) begin
                cSent++;
                cDin = W'(cSent);
            end
            nextCycle();
        end
        cVin = 1'b0;
        if (int'(cOcc) > peak) peak = int'(cOcc);
        checkOutput("C peak occ", peak, 6);
        checkOutput("C full occ", cOcc, 6);
        checkOutput("C full ready", cRdy, 0);
        checkOutput("C no error", cErr, 0);
        cRin = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i < 6) checkOutput("C drain back-to-back", cVout, 1);
            if (cVout) begin
                checkOutput("C drain order", cDout, cExp + 1);
                cExp++;
            end
            cVin = cGrant && (cSent < 12);
            if (cVin) begin
                cSent++;
                cDin = W'(cSent);
            end
            nextCycle();
        end
        cVin = 1'b0;
        checkOutput("C all beats out", cExp, cSent);
        checkOutput("C beats beyond 6", cExp > 6, 1);
        checkOutput("C drained occ", cOcc, 0);
        checkOutput("C still no error", cErr, 0);
        cRin = 1'b0;

        // Violation L=2: fill B, then drive a beat in a slot with no grant.
        doReset();
        bSent = 0;
        bExp  = 0;
        guard = 0;
        while (!(bOcc == 3'd4 && !bGrant) && guard < 30) begin
            bVin = bGrant;
            if (bGrant) begin
                bSent++;
                bDin = W'(bSent);
            end
            nextCycle();
            guard++;
        end
        checkOutput("B fill within bound", guard < 30, 1);
        bVin = 1'b1;
        bDin = 16'hDEAD;
        nextCycle();
        bVin = 1'b0;
        checkOutput("B violation flagged", bErr, 1);
        checkOutput("B violation not stored", bOcc, 4);
        nextCycle();
        checkOutput("B violation sticky", bErr, 1);
        bRin = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bVout) begin
                checkOutput("B drain order no DEAD", bDout, bExp + 1);
                bExp++;
            end
            nextCycle();
        end
        checkOutput("B drained count", bExp, 4);
        checkOutput("B sticky after drain", bErr, 1);
        bRin = 1'b0;
        doReset();
        checkOutput("B err cleared by reset", bErr, 0);

        // Throughput L=2, DEPTH=4: 100 beats leave in 100 consecutive cycles.
        bSent     = 0;
        bExp      = 0;
        guard     = 0;
        firstPush = -1;
        firstOut  = -1;
        lastOut   = -1;
        bRin      = 1'b1;
        while (bExp < 100 && guard < 300) begin
            if (bVout) begin
                checkOutput("B thru data", bDout, bExp);
                if (firstOut < 0) firstOut = cycle;
                lastOut = cycle;
                bExp++;
            end
            bVin = bGrant && (bSent < 100);
            if (bVin) begin
                bDin = W'(bSent);
                if (firstPush < 0) firstPush = cycle;
                bSent++;
            end
            nextCycle();
            guard++;
        end
        bVin = 1'b0;
        checkOutput("B thru count", bExp, 100);
        checkOutput("B thru consecutive", lastOut - firstOut, 99);
        checkOutput("B thru first latency", firstOut - firstPush, 1);
        bRin = 1'b0;
        nextCycle();

        // Reset mid-stream with three beats held.
        doReset();
        bSent = 0;
        guard = 0;
        while (bOcc != 3'd3 && guard < 30) begin
            bVin = bGrant;
            if (bGrant) begin
                bDin = 16'h0100 + W'(bSent);
                bSent++;
            end
            nextCycle();
            guard++;
        end
        checkOutput("B reach occ 3", bOcc, 3);
        bVin = 1'b0;
        rst  = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("B mid reset occ", bOcc, 0);
        checkOutput("B mid reset valid", bVout, 0);
        checkOutput("B mid reset ready", bRdy, 1);
        bRin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            checkOutput("B no stale beat", bVout, 0);
        end
        bRin = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
